// File: rtl/sram_axi_bridge.sv
// SRAM-like instruction/data ports to a single AXI master.
// One read and one write may be in flight; data reads wait behind writes.
module sram_axi_bridge #(
   parameter logic [3:0] INST_ID = 4'd0,
   parameter logic [3:0] DATA_ID = 4'd1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        inst_sram_req,
   input  logic [1:0]  inst_sram_size,
   input  logic [31:0] inst_sram_addr,
   output logic        inst_sram_addr_ok,
   output logic        inst_sram_data_ok,
   output logic [31:0] inst_sram_rdata,
   input  logic        data_sram_req,
   input  logic        data_sram_wr,
   input  logic [1:0]  data_sram_size,
   input  logic [3:0]  data_sram_wstrb,
   input  logic [31:0] data_sram_addr,
   input  logic [31:0] data_sram_wdata,
   output logic        data_sram_addr_ok,
   output logic        data_sram_data_ok,
   output logic [31:0] data_sram_rdata,
   output logic [3:0]  arid,
   output logic [31:0] araddr,
   output logic [2:0]  arsize,
   output logic        arvalid,
   input  logic        arready,
   input  logic [3:0]  rid,
   input  logic [31:0] rdata,
   input  logic        rvalid,
   output logic        rready,
   output logic [31:0] awaddr,
   output logic [2:0]  awsize,
   output logic        awvalid,
   input  logic        awready,
   output logic [31:0] wdata,
   output logic [3:0]  wstrb,
   output logic        wvalid,
   input  logic        wready,
   input  logic        bvalid,
   output logic        bready
);

   typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_e;
   typedef enum logic [1:0] {W_IDLE, W_SEND, W_RESP} w_state_e;

   r_state_e    r_state_q;
   w_state_e    w_state_q;
   logic [31:0] r_addr_q;
   logic [2:0]  r_size_q;
   logic        r_own_q;
   logic        arvalid_q;
   logic        rready_q;
   logic [31:0] w_addr_q;
   logic [2:0]  w_size_q;
   logic [3:0]  w_strb_q;
   logic [31:0] w_data_q;
   logic        awvalid_q;
   logic        wvalid_q;
   logic        bready_q;

   logic r_idle;
   logic w_idle;
   logic d_rd_acc;
   logic i_rd_acc;
   logic wr_acc;
   logic r_done;
   logic unused_rid;

   assign r_idle = (r_state_q == R_IDLE);
   assign w_idle = (w_state_q == W_IDLE);

   assign data_sram_addr_ok = data_sram_req &
      (data_sram_wr ? w_idle : (r_idle & w_idle));
   assign inst_sram_addr_ok = inst_sram_req & r_idle &
      ~(data_sram_req & ~data_sram_wr);

   assign d_rd_acc = data_sram_addr_ok & ~data_sram_wr;
   assign i_rd_acc = inst_sram_addr_ok;
   assign wr_acc   = data_sram_addr_ok & data_sram_wr;

   // rready is held high throughout R_DATA, so rvalid alone completes it
   assign r_done = (r_state_q == R_DATA) & rvalid;

   assign inst_sram_data_ok = r_done & ~r_own_q;
   assign data_sram_data_ok = (r_done & r_own_q) |
      ((w_state_q == W_RESP) & bvalid);
   assign inst_sram_rdata = rdata;
   assign data_sram_rdata = rdata;

   assign arid    = r_own_q ? DATA_ID : INST_ID;
   assign araddr  = r_addr_q;
   assign arsize  = r_size_q;
   assign arvalid = arvalid_q;
   assign rready  = rready_q;
   assign awaddr  = w_addr_q;
   assign awsize  = w_size_q;
   assign awvalid = awvalid_q;
   assign wdata   = w_data_q;
   assign wstrb   = w_strb_q;
   assign wvalid  = wvalid_q;
   assign bready  = bready_q;
   assign unused_rid = ^rid;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state_q <= R_IDLE;
         r_addr_q  <= '0;
         r_size_q  <= '0;
         r_own_q   <= 1'b0;
         arvalid_q <= 1'b0;
         rready_q  <= 1'b0;
      end else begin
         case (r_state_q)
            R_IDLE: if (d_rd_acc | i_rd_acc) begin
               r_addr_q  <= d_rd_acc ? data_sram_addr : inst_sram_addr;
               r_size_q  <= {1'b0, d_rd_acc ? data_sram_size : inst_sram_size};
               r_own_q   <= d_rd_acc;
               arvalid_q <= 1'b1;
               r_state_q <= R_ADDR;
            end
            R_ADDR: if (arready) begin
               arvalid_q <= 1'b0;
               rready_q  <= 1'b1;
               r_state_q <= R_DATA;
            end
            R_DATA: if (rvalid) begin
               rready_q  <= 1'b0;
               r_state_q <= R_IDLE;
            end
            default: r_state_q <= R_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         w_state_q <= W_IDLE;
         w_addr_q  <= '0;
         w_size_q  <= '0;
         w_strb_q  <= '0;
         w_data_q  <= '0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         bready_q  <= 1'b0;
      end else begin
         case (w_state_q)
            W_IDLE: if (wr_acc) begin
               w_addr_q  <= data_sram_addr;
               w_size_q  <= {1'b0, data_sram_size};
               w_strb_q  <= data_sram_wstrb;
               w_data_q  <= data_sram_wdata;
               awvalid_q <= 1'b1;
               wvalid_q  <= 1'b1;
               w_state_q <= W_SEND;
            end
            W_SEND: begin
               if (awvalid_q & awready) awvalid_q <= 1'b0;
               if (wvalid_q & wready) wvalid_q <= 1'b0;
               // each valid doubles as its channel's pending flag
               if ((~awvalid_q | awready) & (~wvalid_q | wready)) begin
                  bready_q  <= 1'b1;
                  w_state_q <= W_RESP;
               end
            end
            W_RESP: if (bvalid) begin
               bready_q  <= 1'b0;
               w_state_q <= W_IDLE;
            end
            default: w_state_q <= W_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed bench for sram_axi_bridge: hand-computed vectors,
// inputs driven at negedge, outputs sampled 1ns later.
module tb_sram_axi_bridge;

   logic        clk = 1'b0;
   logic        reset;
   logic        inst_sram_req;
   logic [1:0]  inst_sram_size;
   logic [31:0] inst_sram_addr;
   logic        inst_sram_addr_ok;
   logic        inst_sram_data_ok;
   logic [31:0] inst_sram_rdata;
   logic        data_sram_req;
   logic        data_sram_wr;
   logic [1:0]  data_sram_size;
   logic [3:0]  data_sram_wstrb;
   logic [31:0] data_sram_addr;
   logic [31:0] data_sram_wdata;
   logic        data_sram_addr_ok;
   logic        data_sram_data_ok;
   logic [31:0] data_sram_rdata;
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [2:0]  arsize;
   logic        arvalid;
   logic        arready;
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic        rvalid;
   logic        rready;
   logic [31:0] awaddr;
   logic [2:0]  awsize;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic        bvalid;
   logic        bready;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   sram_axi_bridge dut (
      .clk(clk), .reset(reset),
      .inst_sram_req(inst_sram_req), .inst_sram_size(inst_sram_size),
      .inst_sram_addr(inst_sram_addr), .inst_sram_addr_ok(inst_sram_addr_ok),
      .inst_sram_data_ok(inst_sram_data_ok), .inst_sram_rdata(inst_sram_rdata),
      .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
      .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
      .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
      .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
      .data_sram_rdata(data_sram_rdata),
      .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid),
      .arready(arready), .rid(rid), .rdata(rdata), .rvalid(rvalid),
      .rready(rready), .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid),
      .awready(awready), .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid),
      .wready(wready), .bvalid(bvalid), .bready(bready)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, ".arvalid"}, 32'(arvalid), 32'd0);
      chk({tag, ".rready"}, 32'(rready), 32'd0);
      chk({tag, ".awvalid"}, 32'(awvalid), 32'd0);
      chk({tag, ".wvalid"}, 32'(wvalid), 32'd0);
      chk({tag, ".bready"}, 32'(bready), 32'd0);
      chk({tag, ".i_dok"}, 32'(inst_sram_data_ok), 32'd0);
      chk({tag, ".d_dok"}, 32'(data_sram_data_ok), 32'd0);
   endtask

   initial begin
      reset = 1'b1;
      inst_sram_req = 0; inst_sram_size = 2'd2; inst_sram_addr = '0;
      data_sram_req = 0; data_sram_wr = 0; data_sram_size = 2'd2;
      data_sram_wstrb = '0; data_sram_addr = '0; data_sram_wdata = '0;
      arready = 1; rid = '0; rdata = '0; rvalid = 0;
      awready = 0; wready = 0; bvalid = 0;

      // reset state
      tick(); settle();
      chk_quiet("rst");
      chk("rst.araddr", araddr, 32'h0);
      chk("rst.awaddr", awaddr, 32'h0);
      tick(); reset = 1'b0; settle();
      chk_quiet("idle");

      // inst read, minimum latency
      tick();
      inst_sram_req = 1; inst_sram_addr = 32'hBFC00000;
      rvalid = 1; rdata = 32'h3C080001;
      settle();
      chk("t1.i_aok", 32'(inst_sram_addr_ok), 32'd1);
      chk("t1.d_aok", 32'(data_sram_addr_ok), 32'd0);
      tick(); inst_sram_req = 0; settle();
      chk("t1.arvalid", 32'(arvalid), 32'd1);
      chk("t1.arid", 32'(arid), 32'd0);
      chk("t1.arsize", 32'(arsize), 32'd2);
      chk("t1.araddr", araddr, 32'hBFC00000);
      chk("t1.i_dok_early", 32'(inst_sram_data_ok), 32'd0);
      tick(); settle();
      chk("t1.rready", 32'(rready), 32'd1);
      chk("t1.arvalid_off", 32'(arvalid), 32'd0);
      chk("t1.i_dok", 32'(inst_sram_data_ok), 32'd1);
      chk("t1.i_rdata", inst_sram_rdata, 32'h3C080001);
      chk("t1.d_dok", 32'(data_sram_data_ok), 32'd0);
      tick(); rvalid = 0; settle();
      chk("t1.i_dok_once", 32'(inst_sram_data_ok), 32'd0);
      chk("t1.rready_off", 32'(rready), 32'd0);

      // inst and data read together: data wins
      tick();
      inst_sram_req = 1; inst_sram_addr = 32'h00001000;
      data_sram_req = 1; data_sram_wr = 0; data_sram_addr = 32'h80002000;
      settle();
      chk("t2.i_aok", 32'(inst_sram_addr_ok), 32'd0);
      chk("t2.d_aok", 32'(data_sram_addr_ok), 32'd1);
      tick(); data_sram_req = 0; settle();
      chk("t2.arid", 32'(arid), 32'd1);
      chk("t2.araddr", araddr, 32'h80002000);
      chk("t2.i_aok_busy", 32'(inst_sram_addr_ok), 32'd0);
      tick(); rvalid = 1; rdata = 32'hAABBCCDD; settle();
      chk("t2.d_dok", 32'(data_sram_data_ok), 32'd1);
      chk("t2.d_rdata", data_sram_rdata, 32'hAABBCCDD);
      chk("t2.i_dok", 32'(inst_sram_data_ok), 32'd0);
      chk("t2.i_aok_rdata", 32'(inst_sram_addr_ok), 32'd0);
      tick(); rvalid = 0; settle();
      chk("t2.i_aok_after", 32'(inst_sram_addr_ok), 32'd1);
      chk("t2.d_dok_once", 32'(data_sram_data_ok), 32'd0);
      tick(); inst_sram_req = 0; settle();
      chk("t2.arid_inst", 32'(arid), 32'd0);
      chk("t2.araddr_inst", araddr, 32'h00001000);
      tick(); rvalid = 1; rdata = 32'h11112222; settle();
      chk("t2.i_dok2", 32'(inst_sram_data_ok), 32'd1);
      chk("t2.i_rdata2", inst_sram_rdata, 32'h11112222);
      tick(); rvalid = 0;

      // write with awready held off 3 cycles, inst read alongside
      tick();
      data_sram_req = 1; data_sram_wr = 1; data_sram_addr = 32'h80001000;
      data_sram_wdata = 32'h12345678; data_sram_wstrb = 4'b0011;
      wready = 1; awready = 0;
      settle();
      chk("t3.d_aok", 32'(data_sram_addr_ok), 32'd1);
      tick();
      data_sram_req = 0; inst_sram_req = 1; inst_sram_addr = 32'hBFC00010;
      settle();
      chk("t3.awvalid1", 32'(awvalid), 32'd1);
      chk("t3.wvalid1", 32'(wvalid), 32'd1);
      chk("t3.awaddr", awaddr, 32'h80001000);
      chk("t3.awsize", 32'(awsize), 32'd2);
      chk("t3.wdata", wdata, 32'h12345678);
      chk("t3.wstrb", 32'(wstrb), 32'h3);
      chk("t3.i_aok", 32'(inst_sram_addr_ok), 32'd1);
      tick();
      inst_sram_req = 0;
      data_sram_req = 1; data_sram_wr = 0; data_sram_addr = 32'h80003000;
      settle();
      chk("t3.wvalid2", 32'(wvalid), 32'd0);
      chk("t3.awvalid2", 32'(awvalid), 32'd1);
      chk("t3.arvalid", 32'(arvalid), 32'd1);
      chk("t3.arid", 32'(arid), 32'd0);
      chk("t3.d_aok_blk2", 32'(data_sram_addr_ok), 32'd0);
      tick(); rvalid = 1; rdata = 32'h5555AAAA; settle();
      chk("t3.i_dok", 32'(inst_sram_data_ok), 32'd1);
      chk("t3.i_rdata", inst_sram_rdata, 32'h5555AAAA);
      chk("t3.awvalid3", 32'(awvalid), 32'd1);
      chk("t3.d_aok_blk3", 32'(data_sram_addr_ok), 32'd0);
      tick(); rvalid = 0; awready = 1; settle();
      chk("t3.awvalid4", 32'(awvalid), 32'd1);
      chk("t3.bready_early", 32'(bready), 32'd0);
      chk("t3.d_aok_blk4", 32'(data_sram_addr_ok), 32'd0);
      tick(); awready = 0; settle();
      chk("t3.awvalid5", 32'(awvalid), 32'd0);
      chk("t3.bready", 32'(bready), 32'd1);
      chk("t3.d_dok_nob", 32'(data_sram_data_ok), 32'd0);
      chk("t3.d_aok_blk5", 32'(data_sram_addr_ok), 32'd0);
      tick(); bvalid = 1; settle();
      chk("t3.w_dok", 32'(data_sram_data_ok), 32'd1);
      chk("t3.d_aok_blk6", 32'(data_sram_addr_ok), 32'd0);
      tick(); bvalid = 0; settle();
      chk("t3.w_dok_once", 32'(data_sram_data_ok), 32'd0);
      chk("t3.bready_off", 32'(bready), 32'd0);
      chk("t3.d_aok_free", 32'(data_sram_addr_ok), 32'd1);
      tick(); data_sram_req = 0; settle();
      chk("t3.rd_arid", 32'(arid), 32'd1);
      chk("t3.rd_araddr", araddr, 32'h80003000);
      tick(); rvalid = 1; rdata = 32'hCAFEF00D; settle();
      chk("t3.rd_dok", 32'(data_sram_data_ok), 32'd1);
      chk("t3.rd_rdata", data_sram_rdata, 32'hCAFEF00D);
      tick(); rvalid = 0;

      // write with both handshakes in the first cycle
      tick();
      data_sram_req = 1; data_sram_wr = 1; data_sram_addr = 32'h00000040;
      data_sram_wdata = 32'hDEADBEEF; data_sram_wstrb = 4'b1111;
      data_sram_size = 2'd1; awready = 1; wready = 1;
      tick(); data_sram_req = 0; settle();
      chk("t4.awsize", 32'(awsize), 32'd1);
      chk("t4.wdata", wdata, 32'hDEADBEEF);
      tick(); settle();
      chk("t4.bready", 32'(bready), 32'd1);
      chk("t4.aw_w_off", 32'({awvalid, wvalid}), 32'd0);
      tick(); bvalid = 1; settle();
      chk("t4.w_dok", 32'(data_sram_data_ok), 32'd1);
      tick(); bvalid = 0; awready = 0; wready = 0; data_sram_size = 2'd2;

      // reset during R_DATA and W_SEND
      tick();
      inst_sram_req = 1; inst_sram_addr = 32'h00002000;
      data_sram_req = 1; data_sram_wr = 1; data_sram_addr = 32'h00003000;
      settle();
      chk("t5.both_aok", 32'({inst_sram_addr_ok, data_sram_addr_ok}), 32'd3);
      tick(); inst_sram_req = 0; data_sram_req = 0;
      tick(); settle();
      chk("t5.rready", 32'(rready), 32'd1);
      chk("t5.awvalid", 32'(awvalid), 32'd1);
      reset = 1'b1; rvalid = 1; settle();
      chk_quiet("t5.rst");
      chk("t5.araddr", araddr, 32'h0);
      inst_sram_req = 1; inst_sram_addr = 32'h00004000;
      tick(); reset = 1'b0; rvalid = 0; settle();
      chk("t5.i_aok_post", 32'(inst_sram_addr_ok), 32'd1);
      tick(); inst_sram_req = 0; settle();
      chk("t5.araddr_post", araddr, 32'h00004000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
